store_lane_unit: RTL

Parametrised, sequential store unit that sits between the execute stage and the data-memory write port. It decodes S-type `funct3` and the store address into byte-lane write enables and steers store data onto the correct lanes. It supports XLEN of 32 or 64 and drives a valid/ready handshake to memory. Optionally, it splits misaligned stores that cross a word boundary into two aligned bus beats.

---
 rtl/store_lane_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/store_lane_unit.sv
// store_lane_unit: S-type store decode, byte-lane steering and a valid/ready
// beat generator toward the data-memory write port.
// Optional feature macro: STORE_SPLIT_MISALIGNED_EN -- when defined, misaligned
// stores are executed (word-crossing ones as two beats) instead of rejected.
module store_lane_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_we,
    output logic              done,
    output logic              exc,
    output logic              exc_cause
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef logic [2*NB-1:0] we2_t;
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              exc_q, exc_d;
    logic              exc_cause_q, exc_cause_d;

    logic [3:0]        size_b;
    logic              illegal;
    we2_t              mask_base;
    logic [OFFW-1:0]   off;
    we2_t              full_we;
    logic [2*XLEN-1:0] full_data_raw;
    logic [2*XLEN-1:0] full_data;
    logic [XLEN-1:0]   aligned_addr;

    assign off          = req_addr[OFFW-1:0];
    assign aligned_addr = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

    // Decode funct3 into access size in bytes and a right-justified lane mask.
    always_comb begin
        size_b    = 4'd0;
        illegal   = 1'b0;
        mask_base = we2_t'(0);
        case (req_funct3)
            3'b000: begin size_b = 4'd1; mask_base = we2_t'(1);  end
            3'b001: begin size_b = 4'd2; mask_base = we2_t'(3);  end
            3'b010: begin size_b = 4'd4; mask_base = we2_t'(15); end
            3'b011: begin
                if (XLEN == 64) begin
                    size_b    = 4'd8;
                    mask_base = we2_t'(255);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    assign full_we       = mask_base << off;
    assign full_data_raw = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};

    // Zero every byte whose write enable is off, so bits above the access
    // size in the right-justified source never reach the bus.
    generate
        for (genvar gi = 0; gi < 2*NB; gi++) begin : g_lane_mask
            assign full_data[gi*8 +: 8] = full_we[gi] ? full_data_raw[gi*8 +: 8] : 8'h00;
        end
    endgenerate

`ifdef STORE_SPLIT_MISALIGNED_EN
    // Second-beat payload captured at acceptance.
    logic              cross_q, cross_d;
    logic [NB-1:0]     hi_we_q, hi_we_d;
    logic [XLEN-1:0]   hi_data_q, hi_data_d;
    logic              crosses;
    assign crosses = (int'(off) + int'(size_b)) > NB;
`else
    logic              misaligned;
    logic              unused_hi;
    assign misaligned = (int'(off) & (int'(size_b) - 1)) != 0;
    // Aligned accesses never spill into the upper half of the lane math.
    assign unused_hi  = ^{full_we[2*NB-1:NB], full_data[2*XLEN-1:XLEN]};
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        done_d      = 1'b0;
        exc_d       = 1'b0;
        exc_cause_d = 1'b0;
`ifdef STORE_SPLIT_MISALIGNED_EN
        cross_d     = cross_q;
        hi_we_d     = hi_we_q;
        hi_data_d   = hi_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        exc_d       = 1'b1;
                        exc_cause_d = 1'b1;
                    end
`ifndef STORE_SPLIT_MISALIGNED_EN
                    else if (misaligned) begin
                        exc_d       = 1'b1;
                        exc_cause_d = 1'b0;
                    end
`endif
                    else begin
                        state_d     = BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = aligned_addr;
                        mem_we_d    = full_we[NB-1:0];
                        mem_wdata_d = full_data[XLEN-1:0];
`ifdef STORE_SPLIT_MISALIGNED_EN
                        cross_d     = crosses;
                        hi_we_d     = full_we[2*NB-1:NB];
                        hi_data_d   = full_data[2*XLEN-1:XLEN];
`endif
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_SPLIT_MISALIGNED_EN
                    if (cross_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + XLEN'(NB);
                        mem_we_d    = hi_we_q;
                        mem_wdata_d = hi_data_q;
                    end else
`endif
                    begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        mem_addr_d  = '0;
                        mem_we_d    = '0;
                        mem_wdata_d = '0;
                        done_d      = 1'b1;
                    end
                end
            end
`ifdef STORE_SPLIT_MISALIGNED_EN
            BEAT1: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_we_d    = '0;
                    mem_wdata_d = '0;
                    done_d      = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any beat in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= '0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            exc_cause_q <= 1'b0;
`ifdef STORE_SPLIT_MISALIGNED_EN
            cross_q     <= 1'b0;
            hi_we_q     <= '0;
            hi_data_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            exc_cause_q <= exc_cause_d;
`ifdef STORE_SPLIT_MISALIGNED_EN
            cross_q     <= cross_d;
            hi_we_q     <= hi_we_d;
            hi_data_q   <= hi_data_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign done      = done_q;
    assign exc       = exc_q;
    assign exc_cause = exc_cause_q;

endmodule
